// File: rtl/config_editor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | config_editor_pkg : phase encodings and duration limits shared by    |
// |                     the configuration editor and its sub-blocks.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package config_editor_pkg;

    typedef enum logic [2:0] {
        ST_RR   = 3'd0,
        ST_GG   = 3'd1,
        ST_YY   = 3'd2,
        ST_IDLE = 3'd3
    } phase_e;

    localparam int c_MIN_TIME_DEFAULT = 1;
    localparam int c_MAX_TIME_DEFAULT = 99;

    // Edited phase cycles red -> green -> yellow -> red.
    function automatic phase_e next_phase(input phase_e i_phase);
        case (i_phase)
            ST_RR:   return ST_GG;
            ST_GG:   return ST_YY;
            default: return ST_RR;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_editor_button_repeat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | config_editor_button_repeat : press-edge detector with optional      |
// |                               hold-to-repeat, one-cycle event out.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module config_editor_button_repeat
    import config_editor_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_event
);

    logic r_prev;
    logic w_press;

    assign w_press = i_btn & ~r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_btn;
        end
    end

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int CNT_W = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
            localparam logic [CNT_W-1:0] c_HOLD   = CNT_W'(HOLD_CYCLES);
            localparam logic [CNT_W-1:0] c_REPEAT = CNT_W'(REPEAT_CYCLES);
            localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_rep;
            logic             w_fire;

            // r_cnt holds edges elapsed since the press (or last repeat);
            // r_rep selects the first-repeat versus steady-repeat interval.
            assign w_fire = i_btn & r_prev & (r_cnt == (r_rep ? c_REPEAT : c_HOLD));

            always_ff @(posedge clk) begin
                if (!reset || !i_btn) begin
                    r_cnt <= '0;
                    r_rep <= 1'b0;
                end else if (w_press || w_fire) begin
                    r_cnt <= c_ONE;
                    r_rep <= w_fire;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end

            assign o_event = w_press | w_fire;
        end else begin : g_no_repeat
            assign o_event = w_press;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/config_editor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | config_editor : interactive editor for red/green/yellow durations    |
// |                 with consistency-checked commit.                     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module config_editor
    import config_editor_pkg::*;
#(
    parameter int TIME_W        = 7,
    parameter int MIN_TIME      = c_MIN_TIME_DEFAULT,
    parameter int MAX_TIME      = c_MAX_TIME_DEFAULT,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              buttonChangeLight,
    input  logic              buttonIncreaseTime,
    input  logic              buttonDecreaseTime,
    input  logic              buttonConfirm,
    input  logic [TIME_W-1:0] greenTime,
    input  logic [TIME_W-1:0] yellowTime,
    input  logic [TIME_W-1:0] redTime,
    output logic [TIME_W-1:0] greenTimeModified,
    output logic [TIME_W-1:0] yellowTimeModified,
    output logic [TIME_W-1:0] redTimeModified,
    output logic [TIME_W-1:0] timeLane1,
    output logic [TIME_W-1:0] timeLane2,
    output logic [2:0]        state,
    output logic              confirmOk,
    output logic              confirmErr,
    output logic              dirty
);

    localparam logic [TIME_W-1:0] c_MIN = TIME_W'(MIN_TIME);
    localparam logic [TIME_W-1:0] c_MAX = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] c_ONE = TIME_W'(1);

    phase_e            r_state, w_state_nxt;
    logic              r_en_prev;
    logic [TIME_W-1:0] r_red, r_green, r_yellow;
    logic [TIME_W-1:0] r_red_mod, r_green_mod, r_yellow_mod;
    logic              r_ok, r_err;

    logic [TIME_W-1:0] w_red_nxt, w_green_nxt, w_yellow_nxt;
    logic [TIME_W-1:0] w_red_mod_nxt, w_green_mod_nxt, w_yellow_mod_nxt;
    logic              w_ok_nxt, w_err_nxt;

    logic              w_ev_chg, w_ev_inc, w_ev_dec, w_ev_cfm;
    logic              w_entry;
    logic [TIME_W-1:0] w_lane, w_stepped;
    logic [TIME_W:0]   w_sum;
    logic              w_commit_ok;

    config_editor_button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
        u_btn_chg (.clk(clk), .reset(reset), .i_btn(buttonChangeLight),  .o_event(w_ev_chg));
    config_editor_button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
        u_btn_inc (.clk(clk), .reset(reset), .i_btn(buttonIncreaseTime), .o_event(w_ev_inc));
    config_editor_button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
        u_btn_dec (.clk(clk), .reset(reset), .i_btn(buttonDecreaseTime), .o_event(w_ev_dec));
    config_editor_button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
        u_btn_cfm (.clk(clk), .reset(reset), .i_btn(buttonConfirm),      .o_event(w_ev_cfm));

    assign w_entry = enable & ~r_en_prev;

    always_comb begin
        case (r_state)
            ST_RR:   w_lane = r_red;
            ST_GG:   w_lane = r_green;
            ST_YY:   w_lane = r_yellow;
            default: w_lane = r_red_mod;
        endcase
    end

    // Out-of-range values snap to the limit the step direction wraps to.
    always_comb begin
        if (w_ev_inc) begin
            w_stepped = (w_lane < c_MIN || w_lane >= c_MAX) ? c_MIN : w_lane + c_ONE;
        end else begin
            w_stepped = (w_lane <= c_MIN || w_lane > c_MAX) ? c_MAX : w_lane - c_ONE;
        end
    end

    assign w_sum       = {1'b0, r_green} + {1'b0, r_yellow};
    assign w_commit_ok = ({1'b0, r_red} == w_sum) && (r_green >= c_MIN) && (r_yellow >= c_MIN);

    always_comb begin
        w_state_nxt      = r_state;
        w_red_nxt        = r_red;
        w_green_nxt      = r_green;
        w_yellow_nxt     = r_yellow;
        w_red_mod_nxt    = r_red_mod;
        w_green_mod_nxt  = r_green_mod;
        w_yellow_mod_nxt = r_yellow_mod;
        w_ok_nxt         = 1'b0;
        w_err_nxt        = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else if (w_entry) begin
            w_state_nxt      = ST_RR;
            w_red_nxt        = redTime;
            w_green_nxt      = greenTime;
            w_yellow_nxt     = yellowTime;
            w_red_mod_nxt    = redTime;
            w_green_mod_nxt  = greenTime;
            w_yellow_mod_nxt = yellowTime;
        end else if (r_state != ST_IDLE) begin
            if (w_ev_chg) begin
                w_state_nxt = next_phase(r_state);
            end else if (w_ev_cfm) begin
                if (w_commit_ok) begin
                    w_red_mod_nxt    = r_red;
                    w_green_mod_nxt  = r_green;
                    w_yellow_mod_nxt = r_yellow;
                    w_ok_nxt         = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end else if (w_ev_inc ^ w_ev_dec) begin
                case (r_state)
                    ST_RR:   w_red_nxt    = w_stepped;
                    ST_GG:   w_green_nxt  = w_stepped;
                    ST_YY:   w_yellow_nxt = w_stepped;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_en_prev    <= 1'b0;
            r_red        <= '0;
            r_green      <= '0;
            r_yellow     <= '0;
            r_red_mod    <= '0;
            r_green_mod  <= '0;
            r_yellow_mod <= '0;
            r_ok         <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_en_prev    <= enable;
            r_red        <= w_red_nxt;
            r_green      <= w_green_nxt;
            r_yellow     <= w_yellow_nxt;
            r_red_mod    <= w_red_mod_nxt;
            r_green_mod  <= w_green_mod_nxt;
            r_yellow_mod <= w_yellow_mod_nxt;
            r_ok         <= w_ok_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign state              = r_state;
    assign timeLane1          = w_lane;
    assign timeLane2          = w_lane;
    assign redTimeModified    = r_red_mod;
    assign greenTimeModified  = r_green_mod;
    assign yellowTimeModified = r_yellow_mod;
    assign confirmOk          = r_ok;
    assign confirmErr         = r_err;
    assign dirty              = (r_red != r_red_mod) || (r_green != r_green_mod) || (r_yellow != r_yellow_mod);

endmodule
`default_nettype wire
